// File: rtl/btn_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module   : btn_pulse_gen
//  Purpose  : Conditions a raw, bouncing push-button into a debounced level
//             (1 = pressed) and single-cycle event pulses. One pulse on each
//             accepted press; optional auto-repeat pulses while held.
//  Ports    : i_clk    - system clock
//             i_res_n  - asynchronous active-low reset
//             i_btn    - raw button pin (asynchronous to i_clk, bounces)
//             o_level  - debounced state, 1 = pressed
//             o_pls    - one-cycle event pulse (press or repeat)
//  Revision : 1.0 - initial release
// ============================================================================
module btn_pulse_gen #(
    parameter int BTN_ACT_LOW  = 1,
    parameter int DEBOUNCE_CYC = 270000,
    parameter int REPEAT_EN    = 0,
    parameter int LONG_CYC     = 13500000,
    parameter int REPEAT_CYC   = 2700000
) (
    input  logic i_clk,
    input  logic i_res_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_pls
);

    // One hold counter serves both the long-press and repeat intervals,
    // so it is sized for the larger of the two.
    localparam int c_hold_max = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
    localparam int c_db_w     = $clog2(DEBOUNCE_CYC + 1);
    localparam int c_hold_w   = $clog2(c_hold_max + 1);

    localparam logic [c_db_w-1:0]   c_db_last   = c_db_w'(DEBOUNCE_CYC - 1);
    localparam logic [c_hold_w-1:0] c_long_last = c_hold_w'(LONG_CYC - 1);
    localparam logic [c_hold_w-1:0] c_rep_last  = c_hold_w'(REPEAT_CYC - 1);

    // Raw pin value that means "not pressed"; synchronizer resets to it so
    // a button held through reset is seen as a fresh press afterwards.
    localparam logic c_released = (BTN_ACT_LOW != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic                w_s_btn;
    logic [c_db_w-1:0]   db_cnt_q, db_cnt_d;
    logic                level_q, level_d;
    logic [c_hold_w-1:0] hold_cnt_q, hold_cnt_d;
    logic                pls_q, pls_d;
    state_t              state_q, state_d;

    // ------------------------------------------------------------------
    // Synchronizer and polarity normalisation
    // ------------------------------------------------------------------
    always_comb begin
        sync1_d = i_btn;
        sync2_d = sync1_q;
        w_s_btn = (BTN_ACT_LOW != 0) ? ~sync2_q : sync2_q;
    end

    // ------------------------------------------------------------------
    // Debounce: a change is accepted only after DEBOUNCE_CYC consecutive
    // cycles of disagreement; any agreement restarts the count. The count
    // is cleared on acceptance, so it never reaches DEBOUNCE_CYC.
    // ------------------------------------------------------------------
    always_comb begin
        db_cnt_d = '0;
        level_d  = level_q;
        if (w_s_btn != level_q) begin
            if (db_cnt_q == c_db_last) begin
                level_d  = w_s_btn;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pulse FSM. It looks at level_d (the value o_level takes on this
    // edge) so the press pulse coincides with o_level rising, and an
    // accepted release pre-empts a repeat pulse due on the same edge.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        pls_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (level_d && !level_q) begin
                    pls_d      = 1'b1;
                    state_d    = ST_HELD;
                    hold_cnt_d = '0;
                end
            end
            ST_HELD: begin
                if (!level_d) begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = '0;
                end else if (REPEAT_EN != 0) begin
                    if (hold_cnt_q == c_long_last) begin
                        pls_d      = 1'b1;
                        state_d    = ST_REPEAT;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            end
            ST_REPEAT: begin
                if (!level_d) begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == c_rep_last) begin
                    pls_d      = 1'b1;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                hold_cnt_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            sync1_q    <= c_released;
            sync2_q    <= c_released;
            db_cnt_q   <= '0;
            level_q    <= 1'b0;
            hold_cnt_q <= '0;
            pls_q      <= 1'b0;
            state_q    <= ST_IDLE;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            db_cnt_q   <= db_cnt_d;
            level_q    <= level_d;
            hold_cnt_q <= hold_cnt_d;
            pls_q      <= pls_d;
            state_q    <= state_d;
        end
    end

    assign o_level = level_q;
    assign o_pls   = pls_q;

endmodule
`default_nettype wire

// File: tb/tb_btn_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_btn_pulse_gen
//  Purpose  : Self-checking bench for btn_pulse_gen. Two instances share one
//             button stimulus: one without auto-repeat, one with. Expected
//             pulse edges are queued when a press is driven and matched
//             against o_pls as it occurs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_btn_pulse_gen;

    logic clk;
    logic res_n;
    logic btn;
    logic level0, pls0;
    logic level1, pls1;

    int cyc    = 0;
    int n_chk  = 0;
    int n_pass = 0;
    int q0[$];
    int q1[$];
    int e;

    btn_pulse_gen #(
        .BTN_ACT_LOW (1),
        .DEBOUNCE_CYC(4),
        .REPEAT_EN   (0),
        .LONG_CYC    (10),
        .REPEAT_CYC  (3)
    ) u_dut0 (
        .i_clk  (clk),
        .i_res_n(res_n),
        .i_btn  (btn),
        .o_level(level0),
        .o_pls  (pls0)
    );

    btn_pulse_gen #(
        .BTN_ACT_LOW (1),
        .DEBOUNCE_CYC(4),
        .REPEAT_EN   (1),
        .LONG_CYC    (10),
        .REPEAT_CYC  (3)
    ) u_dut1 (
        .i_clk  (clk),
        .i_res_n(res_n),
        .i_btn  (btn),
        .o_level(level1),
        .o_pls  (pls1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk = n_chk + 1;
        if (obs == exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse scoreboard: at the falling edge following edge cyc.
    always @(negedge clk) begin
        while (q0.size() > 0 && q0[0] < cyc) begin
            e = q0.pop_front();
            chk("pls0_missing", 0, e);
        end
        if (pls0) begin
            if (q0.size() == 0) begin
                chk("pls0_extra", cyc, -1);
            end else begin
                e = q0.pop_front();
                chk("pls0_edge", cyc, e);
            end
        end
        while (q1.size() > 0 && q1[0] < cyc) begin
            e = q1.pop_front();
            chk("pls1_missing", 0, e);
        end
        if (pls1) begin
            if (q1.size() == 0) begin
                chk("pls1_extra", cyc, -1);
            end else begin
                e = q1.pop_front();
                chk("pls1_edge", cyc, e);
            end
        end
    end

    // Press (drive low) now, hold for 'hold' cycles, then release.
    // Press settles before edge n+1 -> accepted on edge n+6; same for release.
    task automatic press_hold(input int hold);
        int n, p, r, t;
        n   = cyc;
        p   = n + 6;
        r   = n + hold + 6;
        btn = 1'b0;
        q0.push_back(p);
        q1.push_back(p);
        if (p + 10 < r) begin
            q1.push_back(p + 10);
            t = p + 13;
            while (t < r) begin
                q1.push_back(t);
                t = t + 3;
            end
        end
        while (cyc < r + 3) begin
            tick();
            if (cyc == n + hold) btn = 1'b1;
            if (cyc == p - 1) begin
                chk("lvl0_before_press", level0, 0);
                chk("lvl1_before_press", level1, 0);
            end
            if (cyc == p) begin
                chk("lvl0_at_press", level0, 1);
                chk("lvl1_at_press", level1, 1);
            end
            if (cyc == r - 1) begin
                chk("lvl0_before_rel", level0, 1);
                chk("lvl1_before_rel", level1, 1);
            end
            if (cyc == r) begin
                chk("lvl0_at_rel", level0, 0);
                chk("lvl1_at_rel", level1, 0);
            end
        end
    endtask

    initial begin
        int n, p;
        res_n = 1'b0;
        btn   = 1'b0;

        // Reset held with button pressed: outputs stay low.
        repeat (3) begin
            tick();
            chk("rst_lvl0", level0, 0);
            chk("rst_pls0", pls0, 0);
            chk("rst_lvl1", level1, 0);
            chk("rst_pls1", pls1, 0);
        end
        res_n = 1'b1;
        press_hold(8);

        // Clean press and release.
        press_hold(10);

        // Bounce: toggles every 2 cycles, then a settled press.
        for (int i = 0; i < 10; i++) begin
            btn = ~btn;
            tick();
            tick();
        end
        chk("bounce_lvl0", level0, 0);
        chk("bounce_lvl1", level1, 0);
        press_hold(8);

        // Glitch: 3-cycle low pulse is one short of acceptance.
        btn = 1'b0;
        repeat (3) tick();
        btn = 1'b1;
        repeat (12) tick();
        chk("glitch_lvl0", level0, 0);
        chk("glitch_lvl1", level1, 0);

        // Long hold: repeats; a repeat due on the release edge is suppressed.
        press_hold(40);

        // Reset between repeat pulses while still held.
        n   = cyc;
        p   = n + 6;
        btn = 1'b0;
        q0.push_back(p);
        q1.push_back(p);
        q1.push_back(p + 10);
        while (cyc < p + 11) tick();
        res_n = 1'b0;
        #1;
        chk("midrst_lvl1", level1, 0);
        chk("midrst_pls1", pls1, 0);
        chk("midrst_lvl0", level0, 0);
        repeat (2) begin
            tick();
            chk("midrst_hold_pls1", pls1, 0);
        end
        res_n = 1'b1;
        press_hold(8);

        repeat (5) tick();
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
